ifetch_queue: RTL and testbench

- Instruction-fetch stage placed directly upstream of the PC register.
- Drives the PC register's next-PC input, issues in-order requests to instruction memory and buffers returned words with their PCs.
- Presents instructions to decode through a valid/ready interface.
- Handles control-flow redirects by flushing the buffer and discarding stale memory responses.

---
 rtl/ifetch_queue.sv | 126 ++++++++++++
 tb/tb_ifetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: drives next PC, issues in-order imem requests,
// buffers responses for decode. Optional IFETCH_STALL_CNT_EN adds stall_cnt.
module ifetch_queue #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
`ifdef IFETCH_STALL_CNT_EN
  input  logic [31:0] redirect_pc,
  output logic [31:0] stall_cnt
`else
  input  logic [31:0] redirect_pc
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [AW-1:0]         head;
  logic [AW-1:0]         tail;
  logic [AW-1:0]         fill;
  logic [CW-1:0]         alloc_cnt;
  logic [CW-1:0]         out_cnt;
  logic [15:0]           drop_cnt;
  logic [FIFO_DEPTH-1:0] vld;
  logic [31:0]           pc_mem   [FIFO_DEPTH];
  logic [31:0]           data_mem [FIFO_DEPTH];

  logic has_credit;
  logic req_ok;
  logic issue;
  logic head_ok;
  logic pop;
  logic rsp_drop;
  logic rsp_live;

  always_comb begin
    has_credit = (alloc_cnt != FULL);
    req_ok     = !redirect_valid && has_credit;
    issue      = rst && req_ok && imem_req_ready;
    head_ok    = (alloc_cnt != '0) && vld[head];
    pop        = head_ok && instr_ready && !redirect_valid;
    rsp_drop   = imem_rsp_valid && (drop_cnt != '0);
    rsp_live   = imem_rsp_valid && (drop_cnt == '0)
                 && (out_cnt != '0);
  end

  always_comb begin
    imem_req_valid = rst && req_ok;
    imem_req_addr  = pc_in;
    instr_valid    = rst && head_ok;
    instr_out      = rst ? data_mem[head] : '0;
    instr_pc       = rst ? pc_mem[head]   : '0;
    pc_next        = pc_in;
    unique case (1'b1)
      !rst:                       pc_next = RESET_PC;
      rst && redirect_valid:      pc_next = redirect_pc & ~32'h3;
      rst && !redirect_valid && issue:
                                  pc_next = pc_in + 32'd4;
      default:                    pc_next = pc_in;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      fill      <= '0;
      alloc_cnt <= '0;
      out_cnt   <= '0;
      drop_cnt  <= '0;
      vld       <= '0;
    end else if (redirect_valid) begin
      head      <= '0;
      tail      <= '0;
      fill      <= '0;
      alloc_cnt <= '0;
      out_cnt   <= '0;
      vld       <= '0;
      // every request still in flight, less one answered now, is stale
      drop_cnt  <= drop_cnt + 16'(out_cnt)
                   - 16'(rsp_drop || rsp_live);
    end else begin
      if (issue)    tail <= tail + 1'b1;
      if (pop)      head <= head + 1'b1;
      if (rsp_live) fill <= fill + 1'b1;
      alloc_cnt <= alloc_cnt + CW'(issue) - CW'(pop);
      out_cnt   <= out_cnt + CW'(issue) - CW'(rsp_live);
      if (rsp_drop) drop_cnt <= drop_cnt - 16'd1;
      if (pop)      vld[head] <= 1'b0;
      if (rsp_live) vld[fill] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue)
      pc_mem[tail] <= pc_in;
    if (rsp_live && !redirect_valid)
      data_mem[fill] <= imem_rsp_data;
  end

`ifdef IFETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if ((imem_req_valid && !imem_req_ready)
             || (!has_credit && !redirect_valid))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue against a queue-based fetch model
// with an in-order latency memory and a modelled PC register.
module tb_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  ifetch_queue #(
    .FIFO_DEPTH(DEPTH),
    .RESET_PC  (RPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .pc_next       (pc_next),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
`ifdef IFETCH_STALL_CNT_EN
    .redirect_pc   (redirect_pc),
    .stall_cnt     (stall_cnt)
`else
    .redirect_pc   (redirect_pc)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          filled;
  } ent_t;

  typedef struct {
    logic [31:0] data;
    int          due;
    bit          stale;
  } req_t;

  ent_t        q[$];
  req_t        mq[$];
  int          cyc;
  int          last_due;
  logic [31:0] pc_reg;
  logic [31:0] stall_m;
  int          n_chk;
  int          n_pass;
  int          p_redir;
  int          p_rdy;
  int          p_mrdy;
  int          lat_max;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    #1;
    check("rst_pc_next", pc_next, RPC);
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_instr_pc", instr_pc, 0);
    q.delete();
    mq.delete();
    last_due = -1;
    pc_reg   = RPC;
    stall_m  = '0;
    pc_in    = RPC;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    bit          ev_req;
    bit          issue;
    bit          iv;
    bit          pop;
    logic [31:0] exp_pc;
    int          lat;
    int          due;
    req_t        r;
    redirect_valid = ($urandom_range(99) < 32'(p_redir));
    redirect_pc    = $urandom;
    instr_ready    = ($urandom_range(99) < 32'(p_rdy));
    imem_req_ready = ($urandom_range(99) < 32'(p_mrdy));
    pc_in          = pc_reg;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    ev_req = !redirect_valid && q.size() < DEPTH;
    issue  = ev_req && imem_req_ready;
    if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    else if (issue)     exp_pc = pc_in + 32'd4;
    else                exp_pc = pc_in;
    iv  = q.size() > 0 && q[0].filled;
    pop = iv && instr_ready && !redirect_valid;
    check("req_valid", 32'(imem_req_valid), 32'(ev_req));
    check("req_addr", imem_req_addr, pc_in);
    check("pc_next", pc_next, exp_pc);
    check("instr_valid", 32'(instr_valid), 32'(iv));
    if (iv) begin
      check("instr_out", instr_out, q[0].data);
      check("instr_pc", instr_pc, q[0].pc);
    end
`ifdef IFETCH_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall_m);
`endif
    if ((ev_req && !imem_req_ready)
        || (q.size() == DEPTH && !redirect_valid))
      stall_m = stall_m + 32'd1;
    if (imem_rsp_valid) begin
      r = mq.pop_front();
      if (!redirect_valid && !r.stale) begin
        for (int i = 0; i < q.size(); i++) begin
          if (!q[i].filled) begin
            q[i].data   = r.data;
            q[i].filled = 1'b1;
            break;
          end
        end
      end
    end
    if (redirect_valid) begin
      q.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (issue) begin
        q.push_back('{pc: pc_in, data: '0, filled: 1'b0});
        lat = int'($urandom_range(lat_max, 1));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{data: $urandom, due: due, stale: 1'b0});
      end
    end
    pc_reg = exp_pc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n, int redir, int rdy, int mrdy, int lat);
    p_redir = redir;
    p_rdy   = rdy;
    p_mrdy  = mrdy;
    lat_max = lat;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    do_reset();
    run(30, 0, 100, 100, 1);
    run(12, 0, 0, 100, 1);
    run(10, 0, 100, 100, 1);
    run(6, 0, 100, 0, 1);
    run(20, 0, 100, 100, 3);
    run(1500, 10, 70, 70, 4);
    run(5, 0, 0, 100, 3);
    do_reset();
    run(300, 30, 80, 80, 3);
    run(400, 5, 100, 100, 3);
    do_reset();
    run(500, 15, 50, 90, 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
